mb_fetcher: RTL and testbench
=============================

# mb_fetcher

Parametrised macroblock fetcher for the intra-prediction path. On a start request it computes the macroblock origin from a raster macroblock number, then streams the top neighbours, the left neighbours and the macroblock body through a valid/ready pixel port. Pixels come from a shared frame-memory read port with a fixed one-cycle latency: body pixels from the source plane, neighbours from the reconstructed plane. Missing neighbours at frame edges are replaced by 128. It sits between frame memory and the intra predictor/mode-decision stage, and replaces bulk whole-macroblock register copies with a streamed, back-pressurable fetch.

## Interface
- FRAME_W, 64: frame width in pixels; must be a multiple of MB_SIZE.
- FRAME_H, 64: frame height in pixels; must be a multiple of MB_SIZE.
- MB_SIZE, 16: macroblock edge length; legal values 4, 8, 16.
- PIX_W, 8: pixel width in bits.
- ADDR_W, 16: frame-memory address width; must satisfy 2^ADDR_W >= FRAME_W*FRAME_H.
- MBNUM_W, 13: macroblock number width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a fetch; sampled only in IDLE.
- mbnumber  in  MBNUM_W  raster macroblock index; sampled with start.
- busy  out  1  high while a fetch is in progress.
- done  out  1  one-cycle pulse when the fetch completes.
- err  out  1  one-cycle pulse when start is rejected (mbnumber out of range).
- rd_en  out  1  frame-memory read strobe.
- rd_plane  out  1  plane select: 0 = source, 1 = reconstructed.
- rd_addr  out  ADDR_W  pixel address, computed as y*FRAME_W + x.
- rd_data  in  PIX_W  read data, valid exactly one cycle after rd_en.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  downstream accept.
- pix_data  out  PIX_W  pixel value.
- pix_kind  out  2  pixel class: 0 = top, 1 = left, 2 = body, 3 = top-left.
- pix_last  out  1  marks the final pixel of the fetch.

## Operation
- States: IDLE, TOP, TL (macro only), LEFT, BODY, DRAIN.
- Macroblock origin: row0 = (mbnumber / (FRAME_W/MB_SIZE)) * MB_SIZE; col0 = (mbnumber % (FRAME_W/MB_SIZE)) * MB_SIZE.
  - Division and modulus are by constants.
  - The multiply by MB_SIZE is a shift.
- IDLE, start=1:
  - If mbnumber >= (FRAME_W/MB_SIZE)*(FRAME_H/MB_SIZE): pulse err and stay in IDLE.
  - Otherwise latch row0/col0, set busy and go to TOP.
- TOP: MB_SIZE pixels, k = 0..MB_SIZE-1.
  - Reconstructed plane, address (row0-1)*FRAME_W + col0 + k.
  - If row0 = 0: no read is issued and the slot carries the constant 128.
- TL (macro only): one pixel from the reconstructed plane at (row0-1, col0-1); 128 if row0 = 0 or col0 = 0.
- LEFT: MB_SIZE pixels from the reconstructed plane at (row0+i, col0-1); 128 if col0 = 0.
- BODY: MB_SIZE*MB_SIZE pixels from the source plane in raster order, at (row0+j, col0+k).
- Slot pipeline:
  - Every slot, read or constant, passes through the same one-cycle pipeline stage.
  - Slots then enter a 2-entry output FIFO, so order and timing are uniform.
- Issue rule: a slot is issued only when (FIFO occupancy + in-flight slots) < 2, so no data is ever lost under backpressure.
- pix_last is set on the last BODY pixel.
- DRAIN is entered after the last slot issues. It leaves when the FIFO is empty, pulsing done and dropping busy in the same cycle, then returns to IDLE.
- start while busy is ignored and does not raise err.

## Timing
- Reset values: busy=0, done=0, err=0, rd_en=0, rd_plane=0, rd_addr=0, pix_valid=0, pix_data=0, pix_kind=0, pix_last=0; FIFO empty; FSM in IDLE.
- start accepted at edge E0:
  - busy is high after E0.
  - The first slot (rd_en, or a constant) issues in the cycle after E0.
  - rd_data returns after E1.
  - pix_valid is first high after E2, giving a latency of 3 edges.
- Throughput is 1 pixel/cycle with pix_ready held high.
- Total pixels N = MB_SIZE*MB_SIZE + 2*MB_SIZE, plus 1 with the macro.
- done is asserted the edge after the pix_last handshake. IDLE accepts a new start in that same cycle (back-to-back fetches allowed).
- Handshake: pix_data, pix_kind and pix_last must stay stable while pix_valid=1 and pix_ready=0.
- err pulses at the edge after the rejected start.
- Reset mid-fetch:
  - Immediate return to IDLE and the FIFO is flushed.
  - rd_data arriving after reset is discarded.
  - No done pulse is produced.

## Configuration
- MBF_TOPLEFT_EN defined:
  - TL state is compiled in and the top-left pixel is emitted between TOP and LEFT with pix_kind=3.
  - N = MB_SIZE*MB_SIZE + 2*MB_SIZE + 1.
- Undefined:
  - No TL state; pix_kind=3 never occurs.
  - N = MB_SIZE*MB_SIZE + 2*MB_SIZE.

## Test plan
Common setup for all scenarios: FRAME_W=FRAME_H=32, MB_SIZE=16; source memory at address a = a[7:0]; reconstructed memory at address a = ~a[7:0].

- mbnumber=0, pix_ready=1:
  - 16 top pixels of 128, then 16 left pixels of 128.
  - Body: first pixel 0x00, pixel 16 = 0x20, last pixel 0xEF with pix_last.
  - First pix_valid 3 edges after start; done 1 edge after the last handshake.
- mbnumber=3 (row0=16, col0=16):
  - Top k=0 = ~0xF0 = 0x0F.
  - Left i=0 (address 527) = 0xF0.
  - Body first pixel (address 528) = 0x10.
  - With the macro, TL (address 495) = 0x10.
- mbnumber=3 with pix_ready toggling on a random 50% pattern: the pixel sequence is identical to the no-stall run, with no duplicates or drops, and outputs are stable during stalls.
- mbnumber=4: err pulses once, busy stays 0, rd_en is never asserted.
- Reset asserted 40 cycles into a fetch of mbnumber=1:
  - All outputs return to their reset values immediately, and no done pulse occurs.
  - A following mbnumber=1 fetch is complete and correct.
- start held high through the fetch of mbnumber=2: exactly one fetch occurs; a second fetch begins the cycle done pulses.

Source files
------------

// File: rtl/mb_fetcher.sv
// ============================================================================
// Module   : mb_fetcher
// Function : streams top/left neighbours and the body of one macroblock from
//            frame memory through a valid/ready pixel port.
// Option   : MBF_TOPLEFT_EN adds the top-left neighbour pixel (pix_kind=3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module mb_fetcher #(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int MB_SIZE = 16,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 16,
  parameter int MBNUM_W = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MBNUM_W-1:0] mbnumber,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               rd_en,
  output logic               rd_plane,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [PIX_W-1:0]   rd_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [PIX_W-1:0]   pix_data,
  output logic [1:0]         pix_kind,
  output logic               pix_last
);

  localparam int MB_COLS  = FRAME_W / MB_SIZE;
  localparam int MB_ROWS  = FRAME_H / MB_SIZE;
  localparam int MB_COUNT = MB_COLS * MB_ROWS;
  localparam int MB_LOG   = $clog2(MB_SIZE);
  localparam logic [PIX_W-1:0] FILL = PIX_W'(128);
  localparam logic [1:0] KIND_TOP  = 2'd0;
  localparam logic [1:0] KIND_LEFT = 2'd1;
  localparam logic [1:0] KIND_BODY = 2'd2;
  localparam logic [1:0] KIND_TL   = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TOP   = 3'd1,
    LEFT  = 3'd2,
    BODY  = 3'd3,
    DRAIN = 3'd4
`ifdef MBF_TOPLEFT_EN
    , TL  = 3'd5
`endif
  } state_t;

  state_t                r_state;
  logic [ADDR_W-1:0]     r_row0, r_col0;
  logic [MB_LOG-1:0]     r_k, r_j;

  logic                  r_pipe_v, r_pipe_const, r_pipe_last;
  logic [1:0]            r_pipe_kind;
  logic [1:0][PIX_W+2:0] r_fifo;
  logic                  r_wp, r_rp;
  logic [1:0]            r_cnt;

  logic [MBNUM_W-1:0]    w_mb_row, w_mb_col;
  logic [ADDR_W-1:0]     w_row0, w_col0, w_y, w_x, w_addr;
  logic                  w_oor, w_active, w_const, w_plane, w_last;
  logic                  w_k_last, w_j_last, w_pop, w_issue;
  logic [1:0]            w_kind;
  logic [2:0]            w_occ;
  logic [PIX_W-1:0]      w_pipe_data;

  assign w_mb_row = MBNUM_W'(mbnumber / MBNUM_W'(MB_COLS));
  assign w_mb_col = MBNUM_W'(mbnumber % MBNUM_W'(MB_COLS));
  assign w_row0   = ADDR_W'(w_mb_row) << MB_LOG;
  assign w_col0   = ADDR_W'(w_mb_col) << MB_LOG;
  assign w_oor    = ({1'b0, mbnumber} >= (MBNUM_W+1)'(MB_COUNT));

  assign w_k_last = (r_k == MB_LOG'(MB_SIZE - 1));
  assign w_j_last = (r_j == MB_LOG'(MB_SIZE - 1));

  always_comb begin
    w_y      = r_row0 - ADDR_W'(1);
    w_x      = r_col0 + ADDR_W'(r_k);
    w_const  = 1'b0;
    w_kind   = KIND_TOP;
    w_plane  = 1'b1;
    w_last   = 1'b0;
    w_active = 1'b1;
    case (r_state)
      TOP:  w_const = (r_row0 == '0);
`ifdef MBF_TOPLEFT_EN
      TL: begin
        w_x     = r_col0 - ADDR_W'(1);
        w_const = (r_row0 == '0) || (r_col0 == '0);
        w_kind  = KIND_TL;
      end
`endif
      LEFT: begin
        w_y     = r_row0 + ADDR_W'(r_k);
        w_x     = r_col0 - ADDR_W'(1);
        w_const = (r_col0 == '0);
        w_kind  = KIND_LEFT;
      end
      BODY: begin
        w_y     = r_row0 + ADDR_W'(r_j);
        w_kind  = KIND_BODY;
        w_plane = 1'b0;
        w_last  = w_k_last && w_j_last;
      end
      default: w_active = 1'b0;
    endcase
  end

  assign w_addr  = w_y * ADDR_W'(FRAME_W) + w_x;
  assign w_pop   = pix_valid && pix_ready;
  // A slot leaving the FIFO this cycle frees its entry, which keeps 1 pixel/cycle.
  assign w_occ   = {1'b0, r_cnt} + {2'b00, r_pipe_v} - {2'b00, w_pop};
  assign w_issue = w_active && (w_occ < 3'd2);

  assign rd_en    = w_issue && !w_const;
  assign rd_plane = rd_en && w_plane;
  assign rd_addr  = rd_en ? w_addr : '0;

  assign w_pipe_data = r_pipe_const ? FILL : rd_data;
  assign pix_valid   = (r_cnt != 2'd0);
  assign {pix_last, pix_kind, pix_data} = r_fifo[r_rp];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_row0  <= '0;
      r_col0  <= '0;
      r_k     <= '0;
      r_j     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          if (w_oor) begin
            err <= 1'b1;
          end else begin
            r_row0  <= w_row0;
            r_col0  <= w_col0;
            r_k     <= '0;
            r_j     <= '0;
            busy    <= 1'b1;
            r_state <= TOP;
          end
        end
        TOP: if (w_issue) begin
          r_k <= r_k + MB_LOG'(1);
          if (w_k_last) begin
            r_k <= '0;
`ifdef MBF_TOPLEFT_EN
            r_state <= TL;
`else
            r_state <= LEFT;
`endif
          end
        end
`ifdef MBF_TOPLEFT_EN
        TL: if (w_issue) r_state <= LEFT;
`endif
        LEFT: if (w_issue) begin
          r_k <= r_k + MB_LOG'(1);
          if (w_k_last) begin
            r_k     <= '0;
            r_state <= BODY;
          end
        end
        BODY: if (w_issue) begin
          r_k <= r_k + MB_LOG'(1);
          if (w_k_last) begin
            r_k <= '0;
            r_j <= r_j + MB_LOG'(1);
            if (w_j_last) r_state <= DRAIN;
          end
        end
        DRAIN: if (r_cnt == 2'd0 && !r_pipe_v) begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read data and constant slots share this stage so every slot has equal latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pipe_v     <= 1'b0;
      r_pipe_const <= 1'b0;
      r_pipe_kind  <= 2'd0;
      r_pipe_last  <= 1'b0;
      r_fifo       <= '0;
      r_wp         <= 1'b0;
      r_rp         <= 1'b0;
      r_cnt        <= 2'd0;
    end else begin
      r_pipe_v     <= w_issue;
      r_pipe_const <= w_const;
      r_pipe_kind  <= w_kind;
      r_pipe_last  <= w_last;
      if (r_pipe_v) begin
        r_fifo[r_wp] <= {r_pipe_last, r_pipe_kind, w_pipe_data};
        r_wp         <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, r_pipe_v} - {1'b0, w_pop};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mb_fetcher.sv
// ============================================================================
// Module   : tb_mb_fetcher
// Function : scoreboard bench for mb_fetcher on a 32x32 frame, 16x16 blocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mb_fetcher;

  localparam int FW = 32;
  localparam int FH = 32;
  localparam int MB = 16;
  localparam int PW = 8;
  localparam int AW = 16;
  localparam int MW = 13;
`ifdef MBF_TOPLEFT_EN
  localparam int NPIX = MB*MB + 2*MB + 1;
`else
  localparam int NPIX = MB*MB + 2*MB;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [MW-1:0] mbnumber = '0;
  logic          busy, done, err, rd_en, rd_plane;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data = '0;
  logic          pix_valid, pix_last;
  logic          pix_ready = 1'b0;
  logic [PW-1:0] pix_data;
  logic [1:0]    pix_kind;

  int checks = 0;
  int failures = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  mb_fetcher #(
    .FRAME_W(FW), .FRAME_H(FH), .MB_SIZE(MB),
    .PIX_W(PW), .ADDR_W(AW), .MBNUM_W(MW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mbnumber(mbnumber),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_plane(rd_plane), .rd_addr(rd_addr), .rd_data(rd_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_kind(pix_kind), .pix_last(pix_last)
  );

  // Frame memory: source plane = a[7:0], reconstructed plane = ~a[7:0].
  always @(posedge clk)
    rd_data <= rd_en ? (rd_plane ? ~rd_addr[7:0] : rd_addr[7:0]) : 8'h5A;

  task automatic push_expect(input int mb);
    int row0, col0, a;
    logic [7:0] v;
    row0 = (mb / (FW/MB)) * MB;
    col0 = (mb % (FW/MB)) * MB;
    for (int k = 0; k < MB; k++) begin
      a = (row0-1)*FW + col0 + k;
      v = (row0 == 0) ? 8'd128 : ~a[7:0];
      exp_q.push_back({1'b0, 2'd0, v});
    end
`ifdef MBF_TOPLEFT_EN
    a = (row0-1)*FW + col0 - 1;
    v = (row0 == 0 || col0 == 0) ? 8'd128 : ~a[7:0];
    exp_q.push_back({1'b0, 2'd3, v});
`endif
    for (int i = 0; i < MB; i++) begin
      a = (row0+i)*FW + col0 - 1;
      v = (col0 == 0) ? 8'd128 : ~a[7:0];
      exp_q.push_back({1'b0, 2'd1, v});
    end
    for (int j = 0; j < MB; j++)
      for (int k = 0; k < MB; k++) begin
        a = (row0+j)*FW + col0 + k;
        exp_q.push_back({(j == MB-1 && k == MB-1), 2'd2, a[7:0]});
      end
  endtask

  // Entered and left at a negedge; edge 1 is the edge that samples start.
  task automatic run_fetch(input int mb, input bit rnd, input bit keep_start,
                           output int first_n, output int last_hs_n,
                           output int done_n, output int npix, output bit saw_err);
    bit stalled, fin;
    logic [10:0] held, exp;
    push_expect(mb);
    start = 1'b1; mbnumber = MW'(mb); pix_ready = 1'b1;
    first_n = -1; last_hs_n = -1; done_n = -1; npix = 0; saw_err = 1'b0;
    stalled = 1'b0; fin = 1'b0; held = '0;
    for (int n = 1; n <= 3000 && !fin; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (!keep_start) start = 1'b0;
      if (err) saw_err = 1'b1;
      if (done) begin done_n = n; fin = 1'b1; end
      if (pix_valid && first_n < 0) first_n = n;
      if (stalled) begin
        checks++;
        if (!pix_valid || {pix_last, pix_kind, pix_data} !== held) begin
          failures++;
          $display("FAIL stall_stable mb=%0d cycle=%0d got v=%b %h want v=1 %h",
                   mb, n, pix_valid, {pix_last, pix_kind, pix_data}, held);
        end
      end
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pix_valid && pix_ready) begin
        last_hs_n = n + 1;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_pixel mb=%0d got %h want none", mb,
                   {pix_last, pix_kind, pix_data});
        end else begin
          exp = exp_q.pop_front();
          if ({pix_last, pix_kind, pix_data} !== exp) begin
            failures++;
            $display("FAIL pixel mb=%0d idx=%0d got last/kind/data=%h want %h",
                     mb, npix, {pix_last, pix_kind, pix_data}, exp);
          end
        end
        npix++;
      end
      stalled = pix_valid && !pix_ready;
      held = {pix_last, pix_kind, pix_data};
    end
    pix_ready = 1'b0;
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL timeout mb=%0d got no done want done", mb);
    end
    checks++;
    if (exp_q.size() != 0 || npix != NPIX) begin
      failures++;
      $display("FAIL pixel_count mb=%0d got %0d (left %0d) want %0d", mb, npix,
               exp_q.size(), NPIX);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, rd_en, rd_plane, rd_addr, pix_valid, pix_data, pix_kind, pix_last} !== '0) begin
      failures++;
      $display("FAIL reset_values got busy=%b done=%b err=%b rd_en=%b addr=%h valid=%b data=%h want all 0",
               busy, done, err, rd_en, rd_addr, pix_valid, pix_data);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, pix_valid, rd_en} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b valid=%b rd_en=%b want 000", busy, pix_valid, rd_en);
    end
  endtask

  task automatic test_mb0();
    int f, l, d, np; bit e;
    run_fetch(0, 1'b0, 1'b0, f, l, d, np, e);
    checks++;
    if (f != 3) begin failures++; $display("FAIL mb0_latency got %0d want 3", f); end
    checks++;
    if (l != NPIX + 3) begin failures++; $display("FAIL mb0_throughput got %0d want %0d", l, NPIX + 3); end
    checks++;
    if (d != l + 1) begin failures++; $display("FAIL mb0_done_timing got %0d want %0d", d, l + 1); end
    checks++;
    if (busy !== 1'b0 || e) begin failures++; $display("FAIL mb0_end got busy=%b err=%b want 0 0", busy, e); end
  endtask

  task automatic test_mb3();
    int f, l, d, np; bit e;
    run_fetch(3, 1'b0, 1'b0, f, l, d, np, e);
    checks++;
    if (f != 3 || d != l + 1) begin
      failures++;
      $display("FAIL mb3_timing got first=%0d done=%0d want 3 %0d", f, d, l + 1);
    end
  endtask

  task automatic test_stall();
    int f, l, d, np; bit e;
    run_fetch(3, 1'b1, 1'b0, f, l, d, np, e);
    checks++;
    if (d != l + 1) begin failures++; $display("FAIL stall_done_timing got %0d want %0d", d, l + 1); end
  endtask

  task automatic test_err();
    int errs; bit rd_seen, busy_seen;
    errs = 0; rd_seen = 1'b0; busy_seen = 1'b0;
    start = 1'b1; mbnumber = MW'(4);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL err_pulse got %b want 1", err); end
    for (int n = 0; n < 8; n++) begin
      if (err) errs++;
      if (rd_en) rd_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (errs != 1) begin failures++; $display("FAIL err_once got %0d want 1", errs); end
    checks++;
    if (rd_seen || busy_seen) begin
      failures++;
      $display("FAIL err_quiet got rd_en=%b busy=%b want 0 0", rd_seen, busy_seen);
    end
  endtask

  task automatic test_mid_reset();
    int f, l, d, np; bit e, done_seen;
    done_seen = 1'b0;
    start = 1'b1; mbnumber = MW'(1); pix_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (done) done_seen = 1'b1;
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, rd_en, rd_plane, rd_addr, pix_valid, pix_data, pix_kind, pix_last} !== '0) begin
      failures++;
      $display("FAIL midreset_values got busy=%b rd_en=%b addr=%h valid=%b data=%h kind=%0d want all 0",
               busy, rd_en, rd_addr, pix_valid, pix_data, pix_kind);
    end
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    reset = 1'b1;
    pix_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    checks++;
    if (done_seen) begin failures++; $display("FAIL midreset_no_done got done=1 want 0"); end
    run_fetch(1, 1'b0, 1'b0, f, l, d, np, e);
    checks++;
    if (f != 3) begin failures++; $display("FAIL midreset_refetch_latency got %0d want 3", f); end
  endtask

  task automatic test_back_to_back();
    int f, l, d, np; bit e;
    run_fetch(2, 1'b0, 1'b1, f, l, d, np, e);
    checks++;
    if (e) begin failures++; $display("FAIL b2b_no_err got err=1 want 0"); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_drop got %b want 0", busy); end
    // start is still high, so the edge after the done cycle begins the next fetch.
    run_fetch(2, 1'b0, 1'b0, f, l, d, np, e);
    checks++;
    if (f != 3) begin failures++; $display("FAIL b2b_second_start got first=%0d want 3", f); end
  endtask

  initial begin
    test_reset();
    test_mb0();
    test_mb3();
    test_stall();
    test_err();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
